// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded ID state for EX, turns stall/flush into bubbles,
// and bypasses same-cycle WB write data into the operands. Optional counters: ID_EX_PERF_CNT_EN.
module id_ex_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      ID_Inst,
   input  logic [31:0]      ID_PC_plus4,
   input  logic [31:0]      ID_Databus1,
   input  logic [31:0]      ID_Databus2,
   input  logic [31:0]      ID_Ext_out,
   input  logic [1:0]       ID_RegDst,
   input  logic [1:0]       ID_MemtoReg,
   input  logic [3:0]       ID_ALUOp,
   input  logic             ID_ALUSrc1,
   input  logic             ID_ALUSrc2,
   input  logic             ID_MemRead,
   input  logic             ID_MemWrite,
   input  logic             ID_RegWrite,
   input  logic             WB_RegWrite,
   input  logic [4:0]       WB_Write_register,
   input  logic [31:0]      WB_Write_data,
   output logic [31:0]      EX_Inst,
   output logic [31:0]      EX_PC_plus4,
   output logic [31:0]      EX_Databus1,
   output logic [31:0]      EX_Databus2,
   output logic [31:0]      EX_Ext_out,
   output logic [1:0]       EX_RegDst,
   output logic [1:0]       EX_MemtoReg,
   output logic [3:0]       EX_ALUOp,
   output logic             EX_ALUSrc1,
   output logic             EX_ALUSrc2,
   output logic             EX_MemRead,
   output logic             EX_MemWrite,
   output logic             EX_RegWrite,
   output logic [4:0]       EX_Rs,
   output logic [4:0]       EX_Rt,
   output logic [4:0]       EX_Rd,
   output logic [4:0]       EX_Shamt,
   output logic             EX_Valid,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc_plus4;
      logic [31:0] databus1;
      logic [31:0] databus2;
      logic [31:0] ext_out;
      logic [1:0]  reg_dst;
      logic [1:0]  mem_to_reg;
      logic [3:0]  alu_op;
      logic        alu_src1;
      logic        alu_src2;
      logic        mem_read;
      logic        mem_write;
      logic        reg_write;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic        valid;
   } ex_t;

   ex_t        ex_d, ex_q;
   logic [4:0] id_rs, id_rt;
   logic       bypass_a, bypass_b;

   assign id_rs    = ID_Inst[25:21];
   assign id_rt    = ID_Inst[20:16];
   assign bypass_a = WB_RegWrite && (WB_Write_register != 5'd0) && (WB_Write_register == id_rs);
   assign bypass_b = WB_RegWrite && (WB_Write_register != 5'd0) && (WB_Write_register == id_rt);

   always_comb begin
      // NOTE: the all-zero default is also the bubble; assigning it first means no path leaves ex_d unassigned, so no latch.
      ex_d = '0;
      if (!flush && !stall) begin
         ex_d.inst       = ID_Inst;
         ex_d.pc_plus4   = ID_PC_plus4;
         ex_d.databus1   = bypass_a ? WB_Write_data : ID_Databus1;
         ex_d.databus2   = bypass_b ? WB_Write_data : ID_Databus2;
         ex_d.ext_out    = ID_Ext_out;
         ex_d.reg_dst    = ID_RegDst;
         ex_d.mem_to_reg = ID_MemtoReg;
         ex_d.alu_op     = ID_ALUOp;
         ex_d.alu_src1   = ID_ALUSrc1;
         ex_d.alu_src2   = ID_ALUSrc2;
         ex_d.mem_read   = ID_MemRead;
         ex_d.mem_write  = ID_MemWrite;
         ex_d.reg_write  = ID_RegWrite;
         ex_d.rs         = id_rs;
         ex_d.rt         = id_rt;
         ex_d.rd         = ID_Inst[15:11];
         ex_d.shamt      = ID_Inst[10:6];
         ex_d.valid      = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign EX_Inst     = ex_q.inst;
   assign EX_PC_plus4 = ex_q.pc_plus4;
   assign EX_Databus1 = ex_q.databus1;
   assign EX_Databus2 = ex_q.databus2;
   assign EX_Ext_out  = ex_q.ext_out;
   assign EX_RegDst   = ex_q.reg_dst;
   assign EX_MemtoReg = ex_q.mem_to_reg;
   assign EX_ALUOp    = ex_q.alu_op;
   assign EX_ALUSrc1  = ex_q.alu_src1;
   assign EX_ALUSrc2  = ex_q.alu_src2;
   assign EX_MemRead  = ex_q.mem_read;
   assign EX_MemWrite = ex_q.mem_write;
   assign EX_RegWrite = ex_q.reg_write;
   assign EX_Rs       = ex_q.rs;
   assign EX_Rt       = ex_q.rt;
   assign EX_Rd       = ex_q.rd;
   assign EX_Shamt    = ex_q.shamt;
   assign EX_Valid    = ex_q.valid;

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, flush_q;

   // A simultaneous flush and stall is one bubble, charged to flush only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (flush && (flush_q != '1))
            flush_q <= flush_q + CNT_W'(1);
         if (stall && !flush && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
